// File: rtl/alu_op_core_if.sv
// alu_op_core_if: operand, opcode and result bundle for the alu_op_core execute stage.
// master drives operands and opcode; slave (the core) drives result and flags.
interface alu_op_core_if #(
   parameter int WIDTH = 4
);
   logic [WIDTH-1:0]   a;
   logic [WIDTH-1:0]   b;
   logic [3:0]         opcode;
   logic [2*WIDTH-1:0] result;
   logic               gt;
   logic               st;
   logic               eq;
   logic               overflow;
   logic               op_done;

   modport master (
      output a, b, opcode,
      input  result, gt, st, eq, overflow, op_done
   );

   modport slave (
      input  a, b, opcode,
      output result, gt, st, eq, overflow, op_done
   );
endinterface

// File: rtl/alu_op_core.sv
// alu_op_core: single-cycle unsigned arithmetic/logic execute stage.
// Operands are sampled on every rising edge; result and flags are registered.
// Optional feature macro: ALU_DIV_EN builds the divider for opcode 4'b1001;
// without it that opcode is treated as invalid (op_done=0, result/overflow hold).
module alu_op_core #(
   parameter int WIDTH = 4
) (
   input  logic         clk,
   input  logic         rst_n,
   alu_op_core_if.slave bus
);
   localparam logic [3:0] OP_NAND = 4'h0;
   localparam logic [3:0] OP_NOR  = 4'h1;
   localparam logic [3:0] OP_XNOR = 4'h2;
   localparam logic [3:0] OP_GT   = 4'h3;
   localparam logic [3:0] OP_ST   = 4'h4;
   localparam logic [3:0] OP_EQ   = 4'h5;
   localparam logic [3:0] OP_ADD  = 4'h6;
   localparam logic [3:0] OP_SUB  = 4'h7;
   localparam logic [3:0] OP_MUL  = 4'h8;
`ifdef ALU_DIV_EN
   localparam logic [3:0] OP_DIV  = 4'h9;
`endif

   logic [1:0]         rst_sync_r;
   logic               rst_int_n_s;
   logic [2*WIDTH-1:0] a_ext_s;
   logic [2*WIDTH-1:0] b_ext_s;
   logic [2*WIDTH-1:0] sum_s;
   logic [2*WIDTH-1:0] diff_s;
   logic [2*WIDTH-1:0] prod_s;
   logic               a_gt_b_s;
   logic               a_lt_b_s;
   logic               a_eq_b_s;

   logic [2*WIDTH-1:0] result_next_s;
   logic               overflow_next_s;
   logic               done_next_s;
   logic               cmp_load_s;

   logic [2*WIDTH-1:0] result_r;
   logic               overflow_r;
   logic               done_r;
   logic               gt_r;
   logic               st_r;
   logic               eq_r;

   assign rst_int_n_s = rst_sync_r[1];
   assign a_ext_s     = {{WIDTH{1'b0}}, bus.a};
   assign b_ext_s     = {{WIDTH{1'b0}}, bus.b};
   assign sum_s       = a_ext_s + b_ext_s;
   assign diff_s      = a_ext_s - b_ext_s;   // wraps to two's complement when a<b
   assign prod_s      = a_ext_s * b_ext_s;
   assign a_gt_b_s    = (bus.a > bus.b);
   assign a_lt_b_s    = (bus.a < bus.b);
   assign a_eq_b_s    = (bus.a == bus.b);

   // Reset synchroniser: assert immediately, release two clock edges after rst_n rises.
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         rst_sync_r <= 2'b00;
      end else begin
         rst_sync_r <= {rst_sync_r[0], 1'b1};
      end
   end

   // Opcode decode: next result/overflow/done and whether compare flags reload.
   always_comb begin
      result_next_s   = result_r;
      overflow_next_s = overflow_r;
      done_next_s     = 1'b0;
      cmp_load_s      = 1'b0;
      case (bus.opcode)
         OP_NAND: begin
            result_next_s   = {{WIDTH{1'b0}}, ~(bus.a & bus.b)};
            overflow_next_s = 1'b0;
            done_next_s     = 1'b1;
         end
         OP_NOR: begin
            result_next_s   = {{WIDTH{1'b0}}, ~(bus.a | bus.b)};
            overflow_next_s = 1'b0;
            done_next_s     = 1'b1;
         end
         OP_XNOR: begin
            result_next_s   = {{WIDTH{1'b0}}, ~(bus.a ^ bus.b)};
            overflow_next_s = 1'b0;
            done_next_s     = 1'b1;
         end
         OP_GT, OP_ST, OP_EQ: begin
            result_next_s   = {{(2*WIDTH-3){1'b0}}, a_gt_b_s, a_eq_b_s, a_lt_b_s};
            overflow_next_s = 1'b0;
            done_next_s     = 1'b1;
            cmp_load_s      = 1'b1;
         end
         OP_ADD: begin
            result_next_s   = sum_s;
            overflow_next_s = sum_s[WIDTH];
            done_next_s     = 1'b1;
         end
         OP_SUB: begin
            result_next_s   = diff_s;
            overflow_next_s = a_lt_b_s;
            done_next_s     = 1'b1;
         end
         OP_MUL: begin
            result_next_s   = prod_s;
            overflow_next_s = |prod_s[2*WIDTH-1:WIDTH];
            done_next_s     = 1'b1;
         end
`ifdef ALU_DIV_EN
         OP_DIV: begin
            done_next_s = 1'b1;
            if (bus.b == {WIDTH{1'b0}}) begin
               result_next_s   = {(2*WIDTH){1'b1}};
               overflow_next_s = 1'b1;
            end else begin
               result_next_s   = {bus.a % bus.b, bus.a / bus.b};
               overflow_next_s = 1'b0;
            end
         end
`endif
         default: begin
            result_next_s   = result_r;
            overflow_next_s = overflow_r;
            done_next_s     = 1'b0;
            cmp_load_s      = 1'b0;
         end
      endcase
   end

   // Output registers: cleared asynchronously by rst_n, held cleared until the synchroniser releases.
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         result_r   <= {(2*WIDTH){1'b0}};
         overflow_r <= 1'b0;
         done_r     <= 1'b0;
         gt_r       <= 1'b0;
         st_r       <= 1'b0;
         eq_r       <= 1'b0;
      end else if (!rst_int_n_s) begin
         result_r   <= {(2*WIDTH){1'b0}};
         overflow_r <= 1'b0;
         done_r     <= 1'b0;
         gt_r       <= 1'b0;
         st_r       <= 1'b0;
         eq_r       <= 1'b0;
      end else begin
         result_r   <= result_next_s;
         overflow_r <= overflow_next_s;
         done_r     <= done_next_s;
         if (cmp_load_s) begin
            gt_r <= a_gt_b_s;
            st_r <= a_lt_b_s;
            eq_r <= a_eq_b_s;
         end else begin
            gt_r <= gt_r;
            st_r <= st_r;
            eq_r <= eq_r;
         end
      end
   end

   assign bus.result   = result_r;
   assign bus.overflow = overflow_r;
   assign bus.op_done  = done_r;
   assign bus.gt       = gt_r;
   assign bus.st       = st_r;
   assign bus.eq       = eq_r;
endmodule

// File: tb/tb_alu_op_core.sv
// tb_alu_op_core: directed and randomized checks of alu_op_core against an
// integer-arithmetic reference model. Honours ALU_DIV_EN like the design.
module tb_alu_op_core;
   logic clk;
   logic rst_n;
   int   n_cmp;
   int   n_err;

   // reference model state
   int m_res;
   int m_ovf;
   int m_done;
   int m_gt;
   int m_st;
   int m_eq;

   alu_op_core_if #(.WIDTH(4)) bus_if ();

   alu_op_core #(.WIDTH(4)) dut (
      .clk   (clk),
      .rst_n (rst_n),
      .bus   (bus_if)
   );

   // free-running clock, rising edges at 5, 15, 25 ...
   initial begin
      clk = 1'b0;
      forever #5 clk = ~clk;
   end

   task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
      n_cmp = n_cmp + 1;
      if (obs !== exp) begin
         n_err = n_err + 1;
         $display("FAIL %s: got %0h expected %0h", tag, obs, exp);
      end
   endtask

   task automatic model_reset();
      m_res = 0; m_ovf = 0; m_done = 0; m_gt = 0; m_st = 0; m_eq = 0;
   endtask

   task automatic model_step(input int op, input int a, input int b);
      case (op)
         0: begin m_res = (~(a & b)) & 15; m_ovf = 0; m_done = 1; end
         1: begin m_res = (~(a | b)) & 15; m_ovf = 0; m_done = 1; end
         2: begin m_res = (~(a ^ b)) & 15; m_ovf = 0; m_done = 1; end
         3, 4, 5: begin
            m_gt = (a > b) ? 1 : 0;
            m_st = (a < b) ? 1 : 0;
            m_eq = (a == b) ? 1 : 0;
            m_res = m_gt * 4 + m_eq * 2 + m_st;
            m_ovf = 0; m_done = 1;
         end
         6: begin m_res = a + b; m_ovf = (a + b > 15) ? 1 : 0; m_done = 1; end
         7: begin m_res = (a - b + 256) % 256; m_ovf = (a < b) ? 1 : 0; m_done = 1; end
         8: begin m_res = a * b; m_ovf = (a * b > 15) ? 1 : 0; m_done = 1; end
`ifdef ALU_DIV_EN
         9: begin
            m_done = 1;
            if (b == 0) begin m_res = 255; m_ovf = 1; end
            else begin m_res = (a % b) * 16 + a / b; m_ovf = 0; end
         end
`endif
         default: m_done = 0;
      endcase
   endtask

   task automatic check_all(input string tag);
      check({tag, ".result"},   32'(bus_if.result),   32'(m_res));
      check({tag, ".overflow"}, 32'(bus_if.overflow), 32'(m_ovf));
      check({tag, ".op_done"},  32'(bus_if.op_done),  32'(m_done));
      check({tag, ".gt"},       32'(bus_if.gt),       32'(m_gt));
      check({tag, ".st"},       32'(bus_if.st),       32'(m_st));
      check({tag, ".eq"},       32'(bus_if.eq),       32'(m_eq));
   endtask

   // drive at the falling edge, let one rising edge sample, read back at the next falling edge
   task automatic do_op(input int op, input int a, input int b);
      bus_if.opcode = 4'(op);
      bus_if.a      = 4'(a);
      bus_if.b      = 4'(b);
      @(posedge clk);
      model_step(op, a, b);
      @(negedge clk);
   endtask

   // release reset and let the synchroniser settle with an invalid opcode driven
   task automatic release_reset();
      bus_if.opcode = 4'hF;
      bus_if.a      = 4'h0;
      bus_if.b      = 4'h0;
      rst_n = 1'b1;
      repeat (3) @(negedge clk);
   endtask

   initial begin
      n_cmp = 0;
      n_err = 0;
      rst_n = 1'b0;
      bus_if.opcode = 4'h0;
      bus_if.a      = 4'h0;
      bus_if.b      = 4'h0;
      model_reset();
      repeat (2) @(negedge clk);
      check_all("reset");
      release_reset();
      check_all("post_release_idle");

      // mid-stream reset
      do_op(6, 9, 9);
      check("add9p9", 32'(bus_if.result), 32'h12);
      #2 rst_n = 1'b0;
      #1 model_reset();
      check_all("async_reset");
      @(negedge clk);
      release_reset();
      do_op(0, 15, 15);
      check("nand_ff.result", 32'(bus_if.result), 32'h00);
      check("nand_ff.op_done", 32'(bus_if.op_done), 32'h1);

      // logic sweep
      do_op(1, 5, 10); check("nor_5_a", 32'(bus_if.result), 32'h00); check_all("nor");
      do_op(2, 5, 5);  check("xnor_5_5", 32'(bus_if.result), 32'h0F); check_all("xnor");
      do_op(0, 3, 5);  check("nand_3_5", 32'(bus_if.result), 32'h0E); check_all("nand");

      // compare and flag hold
      do_op(3, 7, 3);
      check("cmp_7_3", 32'(bus_if.result), 32'h04);
      check("cmp_7_3.gt", 32'(bus_if.gt), 32'h1);
      do_op(6, 1, 1);
      check("add_1_1", 32'(bus_if.result), 32'h02);
      check("hold.gt", 32'(bus_if.gt), 32'h1);
      do_op(5, 6, 6);
      check("cmp_6_6", 32'(bus_if.result), 32'h02);
      check("cmp_6_6.eq", 32'(bus_if.eq), 32'h1);
      check("cmp_6_6.gt", 32'(bus_if.gt), 32'h0);
      do_op(12, 2, 9);
      check_all("invalid_hold");

      // arithmetic overflow
      do_op(6, 15, 1); check("add_15_1", 32'(bus_if.result), 32'h10); check("add_15_1.ovf", 32'(bus_if.overflow), 32'h1);
      do_op(7, 3, 5);  check("sub_3_5", 32'(bus_if.result), 32'hFE); check("sub_3_5.ovf", 32'(bus_if.overflow), 32'h1);
      do_op(8, 15, 15); check("mul_f_f", 32'(bus_if.result), 32'hE1); check("mul_f_f.ovf", 32'(bus_if.overflow), 32'h1);
      do_op(8, 3, 5);  check("mul_3_5", 32'(bus_if.result), 32'h0F); check("mul_3_5.ovf", 32'(bus_if.overflow), 32'h0);

      // divide
      do_op(9, 13, 4);
`ifdef ALU_DIV_EN
      check("div_13_4", 32'(bus_if.result), 32'h13);
      check("div_13_4.done", 32'(bus_if.op_done), 32'h1);
      do_op(9, 7, 0);
      check("div_7_0", 32'(bus_if.result), 32'hFF);
      check("div_7_0.ovf", 32'(bus_if.overflow), 32'h1);
`else
      check("div_off.result", 32'(bus_if.result), 32'h0F);
      check("div_off.done", 32'(bus_if.op_done), 32'h0);
`endif
      check_all("div");

      // exhaustive sweep of every opcode and operand pair
      for (int op = 0; op < 16; op++) begin
         for (int ab = 0; ab < 256; ab++) begin
            do_op(op, ab / 16, ab % 16);
            check_all($sformatf("sweep_op%0d_a%0d_b%0d", op, ab / 16, ab % 16));
         end
      end

      // randomized mix
      for (int i = 0; i < 600; i++) begin
         do_op(int'($urandom_range(15, 0)), int'($urandom_range(15, 0)), int'($urandom_range(15, 0)));
         check_all($sformatf("rand%0d", i));
      end

      $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
      $finish;
   end
endmodule

// File: doc/alu_op_core.md
Name: alu_op_core

Overview:
- Clocked 4-bit arithmetic/logic operation core: merges the arithmetic unit (add, sub, mul, div) and the logical unit (NAND, NOR, XNOR, compare) behind one opcode decoder.
- Produces an 8-bit registered result, compare flags, an overflow flag and an operation-done strobe.
- Sits in the datapath as the execute stage; samples operands every clock.

Parameters:
- WIDTH, 4, operand width; result width is 2*WIDTH. All values below assume WIDTH=4.

Ports:
- clk  input  1  rising-edge clock
- rst_n  input  1  asynchronous active-low reset
- a  input  WIDTH  operand A, unsigned
- b  input  WIDTH  operand B, unsigned
- opcode  input  4  operation select
- result  output  2*WIDTH  registered result data
- gt  output  1  registered flag, A>B from last compare op
- st  output  1  registered flag, A<B from last compare op
- eq  output  1  registered flag, A==B from last compare op
- overflow  output  1  registered arithmetic overflow/error flag
- op_done  output  1  registered; 1 when the sampled opcode was valid

Behaviour:
- Reset, async on rst_n low: result=0, gt=st=eq=0, overflow=0, op_done=0. Reset is released synchronously to clk internally (2-flop synchroniser on deassert).
- Latency: inputs sampled at a rising edge; all outputs update at that same edge and hold one full cycle. Throughput is one op per cycle. No handshake.
- All arithmetic is unsigned. Logic ops zero-extend the 4-bit value into result[7:4]=0.
- 0000 NAND: result={4'h0, ~(a&b)}. overflow=0.
- 0001 NOR: result={4'h0, ~(a|b)}. overflow=0.
- 0010 XNOR: result={4'h0, ~(a^b)}. overflow=0.
- 0011, 0100 and 0101 (GT, ST, EQ compare): result={5'b0, a>b, a==b, a<b}, one-hot. gt, eq and st are all loaded from this compare for every one of the three opcodes. overflow=0.
- 0110 ADD: result=a+b (0..30). overflow=1 when the sum is >15 (carry out of bit 3).
- 0111 SUB: result=a-b as 8-bit two's complement. When a<b, result=sign-extended negative and overflow=1 (borrow).
- 1000 MUL: result=a*b (0..225). overflow=1 when the product is >15.
- 1001 DIV: result={a%b, a/b}, with the remainder in [7:4] and the quotient in [3:0]. overflow=0. For b==0: result=8'hFF, overflow=1.
- Valid opcodes (0000..1001): op_done=1.
- Opcodes 1010..1111: op_done=0; result and overflow hold their previous values.
- gt, st and eq change only on compare opcodes (0011..0101). They hold across all other opcodes, including invalid ones.
- Exactly one of gt/st/eq is 1 after any compare. All three are 0 only after reset until the first compare.
- No X propagation: a or b carrying X is not required to be handled. Outputs are always driven from flops.

Optional Feature:
- ALU_DIV_EN defined: the combinational divider is built, and opcode 1001 behaves as above.
- ALU_DIV_EN undefined: no divider logic. Opcode 1001 is treated as invalid: op_done=0, and result and overflow hold.

Test Plan:
- Reset mid-stream: drive ADD a=9 b=9, then assert rst_n=0 between edges -> all outputs 0 immediately. After release, the next edge with NAND a=4'hF b=4'hF -> result=8'h00, op_done=1.
- Logic sweep: NOR a=4'h5 b=4'hA -> 8'h00. XNOR a=4'h5 b=4'h5 -> 8'h0F. NAND a=4'h3 b=4'h5 -> 8'h0E. Each appears one edge after sampling.
- Compare/flag hold: opcode 0011 a=7 b=3 -> result=8'h04, gt=1 st=0 eq=0. Then ADD a=1 b=1 -> result=8'h02 with gt still 1. Then opcode 0101 a=6 b=6 -> result=8'h02, eq=1 gt=0.
- Arithmetic overflow: ADD 15+1 -> 8'h10, overflow=1. SUB 3-5 -> 8'hFE, overflow=1. MUL 15*15 -> 8'hE1, overflow=1. MUL 3*5 -> 8'h0F, overflow=0.
- Divide: 13/4 -> 8'h13. 7/0 -> 8'hFF with overflow=1. With ALU_DIV_EN undefined, 13/4 -> op_done=0 and result unchanged.
- Exhaustive sweep of opcodes 0..15 with all 256 {a,b} pairs, checked against a reference model. Opcodes 10..15 -> op_done=0 and result held.
